uart_tx_queue: RTL and testbench

Byte queue with transmitter handshake between the ANSI escape decoder output and the UART transmit input. Absorbs one-cycle `valid` pulses from the decoder, including bursts such as multi-byte escape sequences. Releases bytes one at a time as single-cycle pulses, and only while the UART reports not busy. This removes byte loss when the decoder emits faster than the serial line drains.

---
 rtl/uart_tx_queue.sv | 189 ++++++++++++++++++
 tb/tb_uart_tx_queue.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_queue.sv
// uart_tx_queue: byte FIFO between the ANSI decoder and the UART transmitter, one byte per txBusy handshake.
// Optional CR -> CR LF expansion is built when UART_TXQ_CRLF_EN is defined.
module uart_tx_queue #(
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned AW       = 4,
    parameter int unsigned ACK_WAIT = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [7:0]    inData,
    input  logic          inDataValid,
    input  logic          txBusy,
    output logic [7:0]    outData,
    output logic          outDataValid,
    output logic [AW:0]   count,
    output logic          empty,
    output logic          full,
    output logic          overflow
);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned WW = 4;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ISSUE   = 3'd1,
        S_WAIT_HI = 3'd2,
        S_WAIT_LO = 3'd3,
        S_EMIT_LF = 3'd4
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    state_t        w_state_done;
    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wp;
    logic [AW-1:0] r_rp;
    logic [CW-1:0] r_count;
    logic [CW-1:0] w_count_nxt;
    logic [WW-1:0] r_wait;
    logic [7:0]    r_out_data;
    logic          r_out_valid;
    logic          r_empty;
    logic          r_full;
    logic          r_overflow;
    logic          w_push;
    logic          w_pop;
    logic          w_load_wait;
    logic          w_dec_wait;
`ifdef UART_TXQ_CRLF_EN
    logic          r_cr_pending;
    logic          w_emit_lf;
`endif

    // full is the registered flag, so a same-cycle pop never makes room for a push
    assign w_push = inDataValid & ~r_full;

    // Where the handshake returns once the UART is done with the byte
    always_comb begin
        w_state_done = S_IDLE;
`ifdef UART_TXQ_CRLF_EN
        if (r_cr_pending) begin
            w_state_done = S_EMIT_LF;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (!r_empty && !txBusy) begin
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: w_state_nxt = S_WAIT_HI;
            S_WAIT_HI: begin
                if (txBusy) begin
                    w_state_nxt = S_WAIT_LO;
                end else if (r_wait <= WW'(1)) begin
                    w_state_nxt = w_state_done;
                end
            end
            S_WAIT_LO: begin
                if (!txBusy) begin
                    w_state_nxt = w_state_done;
                end
            end
`ifdef UART_TXQ_CRLF_EN
            S_EMIT_LF: w_state_nxt = S_ISSUE;
`endif
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_pop       = 1'b0;
        w_load_wait = 1'b0;
        w_dec_wait  = 1'b0;
`ifdef UART_TXQ_CRLF_EN
        w_emit_lf   = 1'b0;
`endif
        case (r_state)
            S_IDLE:    w_pop       = ~r_empty & ~txBusy;
            S_ISSUE:   w_load_wait = 1'b1;
            S_WAIT_HI: w_dec_wait  = ~txBusy & (r_wait != '0);
`ifdef UART_TXQ_CRLF_EN
            S_EMIT_LF: w_emit_lf   = 1'b1;
`endif
            default: ;
        endcase
    end

    always_comb begin
        w_count_nxt = r_count;
        if (w_push && !w_pop) begin
            w_count_nxt = r_count + CW'(1);
        end else if (!w_push && w_pop) begin
            w_count_nxt = r_count - CW'(1);
        end
    end

    // Storage is not cleared by reset; the pointers define what is valid
    always_ff @(posedge clk) begin
        if (w_push && !reset) begin
            r_mem[r_wp] <= inData;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wp         <= '0;
            r_rp         <= '0;
            r_count      <= '0;
            r_empty      <= 1'b1;
            r_full       <= 1'b0;
            r_overflow   <= 1'b0;
            r_out_data   <= 8'h00;
            r_out_valid  <= 1'b0;
            r_wait       <= '0;
`ifdef UART_TXQ_CRLF_EN
            r_cr_pending <= 1'b0;
`endif
        end else begin
            if (w_push) begin
                r_wp <= r_wp + AW'(1);
            end
            if (w_pop) begin
                r_rp       <= r_rp + AW'(1);
                r_out_data <= r_mem[r_rp];
            end
            r_count     <= w_count_nxt;
            r_empty     <= (w_count_nxt == '0);
            r_full      <= (w_count_nxt == CW'(DEPTH));
            r_out_valid <= (w_state_nxt == S_ISSUE);
            if (inDataValid && r_full) begin
                r_overflow <= 1'b1;
            end
            if (w_load_wait) begin
                r_wait <= WW'(ACK_WAIT);
            end else if (w_dec_wait) begin
                r_wait <= r_wait - WW'(1);
            end
`ifdef UART_TXQ_CRLF_EN
            if (w_pop) begin
                r_cr_pending <= (r_mem[r_rp] == 8'h0D);
            end else if (w_emit_lf) begin
                r_cr_pending <= 1'b0;
                r_out_data   <= 8'h0A;
            end
`endif
        end
    end

    assign outData      = r_out_data;
    assign outDataValid = r_out_valid;
    assign count        = r_count;
    assign empty        = r_empty;
    assign full         = r_full;
    assign overflow     = r_overflow;

endmodule

// File: tb/tb_uart_tx_queue.sv
// Self-checking bench for uart_tx_queue: scoreboard of pushed bytes against observed issue strobes.
module tb_uart_tx_queue;
    localparam int unsigned DEPTH    = 16;
    localparam int unsigned AW       = 4;
    localparam int unsigned ACK_WAIT = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [7:0]    inData = 8'h00;
    logic          inDataValid = 1'b0;
    logic          txBusy = 1'b0;
    logic [7:0]    outData;
    logic          outDataValid;
    logic [AW:0]   count;
    logic          empty;
    logic          full;
    logic          overflow;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    logic [7:0] exp_q[$];
    logic [7:0] obs_data[$];
    int         obs_cyc[$];

    bit uart_en    = 1'b0;
    bit force_busy = 1'b0;
    int busy_rem   = 0;

    uart_tx_queue #(.DEPTH(DEPTH), .AW(AW), .ACK_WAIT(ACK_WAIT)) dut (
        .clk(clk), .reset(reset), .inData(inData), .inDataValid(inDataValid),
        .txBusy(txBusy), .outData(outData), .outDataValid(outDataValid),
        .count(count), .empty(empty), .full(full), .overflow(overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Issue monitor and UART model: busy for 20 cycles starting one cycle after each issue
    always @(negedge clk) begin
        if (outDataValid === 1'b1) begin
            obs_data.push_back(outData);
            obs_cyc.push_back(cyc);
        end
        if (uart_en) begin
            if (busy_rem > 0) begin
                txBusy = 1'b1;
                busy_rem--;
            end else begin
                txBusy = 1'b0;
            end
            if (outDataValid === 1'b1) busy_rem = 20;
        end else begin
            txBusy   = force_busy;
            busy_rem = 0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_byte(input logic [7:0] b, input bit kept);
        inData      = b;
        inDataValid = 1'b1;
        if (kept) exp_q.push_back(b);
        tick();
        inDataValid = 1'b0;
    endtask

    task automatic wait_obs(input int n, input int budget, output bit ok);
        int k = 0;
        while (obs_data.size() < n && k < budget) begin
            tick();
            k++;
        end
        ok = (obs_data.size() >= n);
    endtask

    task automatic clear_sb();
        exp_q.delete();
        obs_data.delete();
        obs_cyc.delete();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        n_vec++; if (outData !== 8'h00)    begin n_err++; $display("FAIL reset_outData: got %h, want 00", outData); end
        n_vec++; if (outDataValid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b, want 0", outDataValid); end
        n_vec++; if (count !== 5'd0)       begin n_err++; $display("FAIL reset_count: got %0d, want 0", count); end
        n_vec++; if (empty !== 1'b1)       begin n_err++; $display("FAIL reset_empty: got %b, want 1", empty); end
        n_vec++; if (full !== 1'b0)        begin n_err++; $display("FAIL reset_full: got %b, want 0", full); end
        n_vec++; if (overflow !== 1'b0)    begin n_err++; $display("FAIL reset_overflow: got %b, want 0", overflow); end
    endtask

    task automatic test_single();
        int p;
        bit ok;
        logic [7:0] e, o;
        clear_sb();
        p = cyc;
        push_byte(8'h41, 1'b1);
        n_vec++; if (count !== 5'd1) begin n_err++; $display("FAIL single_count1: got %0d, want 1", count); end
        n_vec++; if (empty !== 1'b0) begin n_err++; $display("FAIL single_empty0: got %b, want 0", empty); end
        tick();
        n_vec++; if (count !== 5'd0) begin n_err++; $display("FAIL single_count0: got %0d, want 0", count); end
        n_vec++; if (outDataValid !== 1'b1) begin n_err++; $display("FAIL single_valid: got %b, want 1", outDataValid); end
        tick();
        n_vec++; if (outDataValid !== 1'b0) begin n_err++; $display("FAIL single_pulse: got %b, want 0", outDataValid); end
        n_vec++; if (empty !== 1'b1) begin n_err++; $display("FAIL single_empty1: got %b, want 1", empty); end
        wait_obs(1, 10, ok);
        n_vec++;
        if (!ok) begin
            n_err++; $display("FAIL single_timeout: got %0d issues, want 1", obs_data.size());
        end else if (obs_cyc[0] != p + 2) begin
            n_err++; $display("FAIL single_latency: got %0d cycles, want 2", obs_cyc[0] - p);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (obs_data.size() > 0) ? obs_data.pop_front() : 8'hxx;
            n_vec++; if (o !== e) begin n_err++; $display("FAIL single_data: got %h, want %h", o, e); end
        end
    endtask

    task automatic test_burst();
        bit ok;
        logic [7:0] e, o;
        logic [7:0] bytes [4] = '{8'h1B, 8'h5B, 8'h32, 8'h4A};
        clear_sb();
        uart_en = 1'b1;
        for (int i = 0; i < 4; i++) push_byte(bytes[i], 1'b1);
        wait_obs(4, 200, ok);
        n_vec++;
        if (!ok) begin
            n_err++; $display("FAIL burst_timeout: got %0d issues, want 4", obs_data.size());
        end else begin
            for (int i = 1; i < 4; i++) begin
                n_vec++;
                if (obs_cyc[i] - obs_cyc[i-1] != 23) begin
                    n_err++; $display("FAIL burst_spacing[%0d]: got %0d, want 23", i, obs_cyc[i] - obs_cyc[i-1]);
                end
            end
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (obs_data.size() > 0) ? obs_data.pop_front() : 8'hxx;
            n_vec++; if (o !== e) begin n_err++; $display("FAIL burst_data: got %h, want %h", o, e); end
        end
        n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL burst_overflow: got %b, want 0", overflow); end
        repeat (30) tick();
        uart_en = 1'b0;
        tick();
    endtask

    task automatic test_overflow();
        bit ok;
        logic [7:0] e, o;
        clear_sb();
        force_busy = 1'b1;
        tick();
        for (int i = 0; i < 17; i++) begin
            if (i == 16) begin
                n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL ovf_early: got %b, want 0", overflow); end
            end
            push_byte(8'(i), i < 16);
            if (i == 15) begin
                n_vec++; if (full !== 1'b1)   begin n_err++; $display("FAIL ovf_full: got %b, want 1", full); end
                n_vec++; if (count !== 5'd16) begin n_err++; $display("FAIL ovf_count16: got %0d, want 16", count); end
            end
        end
        n_vec++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_flag: got %b, want 1", overflow); end
        n_vec++; if (count !== 5'd16)   begin n_err++; $display("FAIL ovf_count17: got %0d, want 16", count); end
        force_busy = 1'b0;
        wait_obs(16, 300, ok);
        n_vec++; if (!ok) begin n_err++; $display("FAIL ovf_timeout: got %0d issues, want 16", obs_data.size()); end
        repeat (20) tick();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (obs_data.size() > 0) ? obs_data.pop_front() : 8'hxx;
            n_vec++; if (o !== e) begin n_err++; $display("FAIL ovf_data: got %h, want %h", o, e); end
        end
        n_vec++; if (obs_data.size() != 0) begin n_err++; $display("FAIL ovf_extra: got %0d extra issues, want 0", obs_data.size()); end
        n_vec++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_sticky: got %b, want 1", overflow); end
    endtask

    task automatic test_push_pop_full();
        bit ok;
        logic [7:0] e, o;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        clear_sb();
        n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL ppf_ovf_clear: got %b, want 0", overflow); end
        force_busy = 1'b1;
        tick();
        for (int i = 0; i < 16; i++) push_byte(8'h20 + 8'(i), 1'b1);
        n_vec++; if (full !== 1'b1) begin n_err++; $display("FAIL ppf_full: got %b, want 1", full); end
        force_busy  = 1'b0;
        inData      = 8'hAA;
        inDataValid = 1'b1;
        tick();
        inDataValid = 1'b0;
        n_vec++; if (count !== 5'd15)   begin n_err++; $display("FAIL ppf_count: got %0d, want 15", count); end
        n_vec++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ppf_overflow: got %b, want 1", overflow); end
        n_vec++; if (full !== 1'b0)     begin n_err++; $display("FAIL ppf_notfull: got %b, want 0", full); end
        wait_obs(16, 300, ok);
        n_vec++; if (!ok) begin n_err++; $display("FAIL ppf_timeout: got %0d issues, want 16", obs_data.size()); end
        repeat (20) tick();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (obs_data.size() > 0) ? obs_data.pop_front() : 8'hxx;
            n_vec++; if (o !== e) begin n_err++; $display("FAIL ppf_data: got %h, want %h", o, e); end
        end
        n_vec++; if (obs_data.size() != 0) begin n_err++; $display("FAIL ppf_extra: got %0d extra issues, want 0", obs_data.size()); end
    endtask

    task automatic test_no_busy();
        bit ok;
        logic [7:0] e, o;
        clear_sb();
        force_busy = 1'b0;
        for (int i = 0; i < 3; i++) push_byte(8'h50 + 8'(i), 1'b1);
        wait_obs(3, 100, ok);
        n_vec++;
        if (!ok) begin
            n_err++; $display("FAIL nobusy_timeout: got %0d issues, want 3", obs_data.size());
        end else begin
            for (int i = 1; i < 3; i++) begin
                n_vec++;
                if (obs_cyc[i] - obs_cyc[i-1] != int'(ACK_WAIT) + 2) begin
                    n_err++; $display("FAIL nobusy_spacing[%0d]: got %0d, want %0d", i, obs_cyc[i] - obs_cyc[i-1], ACK_WAIT + 2);
                end
            end
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (obs_data.size() > 0) ? obs_data.pop_front() : 8'hxx;
            n_vec++; if (o !== e) begin n_err++; $display("FAIL nobusy_data: got %h, want %h", o, e); end
        end
        repeat (10) tick();
    endtask

    task automatic test_reset_mid();
        bit ok;
        int p;
        logic [7:0] e, o;
        clear_sb();
        for (int i = 0; i < 5; i++) push_byte(8'h60 + 8'(i), 1'b1);
        wait_obs(1, 20, ok);
        n_vec++; if (!ok) begin n_err++; $display("FAIL rstmid_timeout: got %0d issues, want 1", obs_data.size()); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        clear_sb();
        n_vec++; if (count !== 5'd0)        begin n_err++; $display("FAIL rstmid_count: got %0d, want 0", count); end
        n_vec++; if (empty !== 1'b1)        begin n_err++; $display("FAIL rstmid_empty: got %b, want 1", empty); end
        n_vec++; if (outDataValid !== 1'b0) begin n_err++; $display("FAIL rstmid_valid: got %b, want 0", outDataValid); end
        n_vec++; if (outData !== 8'h00)     begin n_err++; $display("FAIL rstmid_outData: got %h, want 00", outData); end
        repeat (10) tick();
        n_vec++; if (obs_data.size() != 0) begin n_err++; $display("FAIL rstmid_stale: got %0d issues, want 0", obs_data.size()); end
        p = cyc;
        push_byte(8'h55, 1'b1);
        wait_obs(1, 20, ok);
        n_vec++;
        if (!ok) begin
            n_err++; $display("FAIL rstmid_timeout2: got %0d issues, want 1", obs_data.size());
        end else if (obs_cyc[0] != p + 2) begin
            n_err++; $display("FAIL rstmid_latency: got %0d cycles, want 2", obs_cyc[0] - p);
        end
        repeat (20) tick();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (obs_data.size() > 0) ? obs_data.pop_front() : 8'hxx;
            n_vec++; if (o !== e) begin n_err++; $display("FAIL rstmid_data: got %h, want %h", o, e); end
        end
        n_vec++; if (obs_data.size() != 0) begin n_err++; $display("FAIL rstmid_extra: got %0d extra issues, want 0", obs_data.size()); end
    endtask

    task automatic test_crlf();
        bit ok;
        int n_exp;
        logic [7:0] e, o;
        clear_sb();
        push_byte(8'h0D, 1'b1);
`ifdef UART_TXQ_CRLF_EN
        exp_q.push_back(8'h0A);
`endif
        n_exp = exp_q.size();
        n_vec++; if (count !== 5'd1) begin n_err++; $display("FAIL crlf_count1: got %0d, want 1", count); end
        wait_obs(n_exp, 50, ok);
        n_vec++; if (!ok) begin n_err++; $display("FAIL crlf_timeout: got %0d issues, want %0d", obs_data.size(), n_exp); end
        repeat (20) tick();
        n_vec++; if (count !== 5'd0) begin n_err++; $display("FAIL crlf_count0: got %0d, want 0", count); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (obs_data.size() > 0) ? obs_data.pop_front() : 8'hxx;
            n_vec++; if (o !== e) begin n_err++; $display("FAIL crlf_data: got %h, want %h", o, e); end
        end
        n_vec++; if (obs_data.size() != 0) begin n_err++; $display("FAIL crlf_extra: got %0d extra issues, want 0", obs_data.size()); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_burst();
        test_overflow();
        test_push_pop_full();
        test_no_busy();
        test_reset_mid();
        test_crlf();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, got cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
